// File: rtl/sdio_arb_pkg.sv
// Shared types and sizing helpers for the sdcard block-port arbiter.
package sdio_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, XFER} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} sd_op_t;

  localparam int unsigned BLOCK_BYTES_DEF = 512;
  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES_DEF + 1);

  function automatic int unsigned cnt_width(input int unsigned bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/sdcard_io_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the farthest offset back to ptr so the nearest requester overwrites last.
  always_comb begin
    int unsigned j;
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_i) + (N_REQ - 1 - k)) % N_REQ;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sdcard_io_arbiter.sv
// Round-robin block-transaction arbiter in front of the sdcard_subsystem block port.
// Optional per-requester completed-block counters: define SDIO_ARB_STATS_EN.
module sdcard_io_arbiter
  import sdio_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_rd,
  input  logic [N_REQ-1:0]     req_wr,
  input  logic [N_REQ*32-1:0]  req_lba,
  output logic [N_REQ-1:0]     req_ack,
  output logic [7:0]           req_din,
  output logic [N_REQ-1:0]     req_din_tvalid,
  input  logic [N_REQ*8-1:0]   req_dout,
  output logic [N_REQ-1:0]     req_dout_taken,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  input  logic                 disk_mounted,
  output logic [31:0]          io_lba,
  output logic                 io_rd,
  output logic                 io_wr,
  input  logic                 io_ack,
  input  logic [7:0]           io_din,
  input  logic                 io_din_tvalid,
  output logic [7:0]           io_dout,
  input  logic                 io_dout_tvalid,
  output logic [N_REQ*32-1:0]  stat_blocks
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW    = cnt_width(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);

  arb_state_t       state_q, state_d;
  sd_op_t           op_q, op_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             io_rd_q, io_rd_d;
  logic             io_wr_q, io_wr_d;
  logic [31:0]      lba_q, lba_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;

  logic [N_REQ-1:0] any_req;
  logic [N_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_next;
  logic             beat;

  assign any_req  = req_rd | req_wr;
  assign ptr_next = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (any_req),
    .ptr_i   (ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      io_rd_q <= 1'b0;
      io_wr_q <= 1'b0;
      lba_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      io_rd_q <= io_rd_d;
      io_wr_q <= io_wr_d;
      lba_q   <= lba_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    g_d            = g_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    io_rd_d        = io_rd_q;
    io_wr_d        = io_wr_q;
    lba_d          = lba_q;
    done_d         = '0;
    err_d          = '0;
    beat           = 1'b0;
    req_ack        = '0;
    req_din        = '0;
    req_din_tvalid = '0;
    req_dout_taken = '0;
    io_dout        = '0;

    unique case (state_q)
      IDLE: begin
        if (disk_mounted && (|gnt_oh)) begin
          g_d   = gnt_idx;
          lba_d = req_lba[32*int'(gnt_idx) +: 32];
          if (req_rd[gnt_idx]) begin
            op_d    = OP_RD;
            io_rd_d = 1'b1;
          end else begin
            op_d    = OP_WR;
            io_wr_d = 1'b1;
          end
          state_d = CMD;
        end
      end
      CMD: begin
        if (!disk_mounted) begin
          err_d[g_q] = 1'b1;
          io_rd_d    = 1'b0;
          io_wr_d    = 1'b0;
          cnt_d      = '0;
          ptr_d      = ptr_next;
          state_d    = IDLE;
        end else if (io_ack) begin
          req_ack[g_q] = 1'b1;
          io_rd_d      = 1'b0;
          io_wr_d      = 1'b0;
          state_d      = XFER;
        end
      end
      XFER: begin
        req_din = io_din;
        io_dout = req_dout[8*int'(g_q) +: 8];
        if (op_q == OP_RD) begin
          req_din_tvalid[g_q] = io_din_tvalid;
          beat                = io_din_tvalid;
        end else begin
          req_dout_taken[g_q] = io_dout_tvalid;
          beat                = io_dout_tvalid;
        end
        if (!disk_mounted) begin
          err_d[g_q] = 1'b1;
          io_rd_d    = 1'b0;
          io_wr_d    = 1'b0;
          cnt_d      = '0;
          ptr_d      = ptr_next;
          state_d    = IDLE;
        end else if (beat) begin
          if (cnt_q == LAST_BYTE) begin
            cnt_d       = '0;
            done_d[g_q] = 1'b1;
            ptr_d       = ptr_next;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_rd    = io_rd_q;
  assign io_wr    = io_wr_q;
  assign io_lba   = lba_q;
  assign req_done = done_q;
  assign req_err  = err_q;

`ifdef SDIO_ARB_STATS_EN
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_stat
    logic [31:0] blk_q, blk_d;
    assign blk_d = (done_q[i] && (blk_q != '1)) ? blk_q + 32'd1 : blk_q;
    always_ff @(posedge clk) begin
      if (!resetn) blk_q <= '0;
      else         blk_q <= blk_d;
    end
    assign stat_blocks[32*i +: 32] = blk_q;
  end
`else
  assign stat_blocks = '0;
`endif

endmodule

// File: tb/tb_sdcard_io_arbiter.sv
// Directed self-checking bench for sdcard_io_arbiter (N_REQ=2, 512-byte blocks).
module tb_sdcard_io_arbiter;

  localparam int BB = 512;
`ifdef SDIO_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_rd, req_wr;
  logic [63:0] req_lba;
  logic [1:0]  req_ack;
  logic [7:0]  req_din;
  logic [1:0]  req_din_tvalid;
  logic [15:0] req_dout;
  logic [1:0]  req_dout_taken;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic        disk_mounted;
  logic [31:0] io_lba;
  logic        io_rd, io_wr;
  logic        io_ack;
  logic [7:0]  io_din;
  logic        io_din_tvalid;
  logic [7:0]  io_dout;
  logic        io_dout_tvalid;
  logic [63:0] stat_blocks;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdcard_io_arbiter #(.N_REQ(2), .BLOCK_BYTES(BB)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_rd         (req_rd),
    .req_wr         (req_wr),
    .req_lba        (req_lba),
    .req_ack        (req_ack),
    .req_din        (req_din),
    .req_din_tvalid (req_din_tvalid),
    .req_dout       (req_dout),
    .req_dout_taken (req_dout_taken),
    .req_done       (req_done),
    .req_err        (req_err),
    .disk_mounted   (disk_mounted),
    .io_lba         (io_lba),
    .io_rd          (io_rd),
    .io_wr          (io_wr),
    .io_ack         (io_ack),
    .io_din         (io_din),
    .io_din_tvalid  (io_din_tvalid),
    .io_dout        (io_dout),
    .io_dout_tvalid (io_dout_tvalid),
    .stat_blocks    (stat_blocks)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] st(input int c1, input int c0);
    return STATS ? {32'(c1), 32'(c0)} : 64'd0;
  endfunction

  function automatic logic [7:0] wpat(input int k);
    case (k % 3)
      0:       return 8'hFA;
      1:       return 8'h33;
      default: return 8'hC0;
    endcase
  endfunction

  // Plays the subsystem side of one block. abort_at >= 0 stops after that many
  // beats, by unmount (abort_rst=0) or by synchronous reset (abort_rst=1).
  task automatic xfer_block(input int own, input bit wr, input logic [31:0] lba,
                            input int abort_at, input bit abort_rst, input bit keep);
    int n, got_own, got_oth, bad, idx;
    logic [7:0] d;
    n = 0; got_own = 0; got_oth = 0; bad = 0; idx = 0;
    while (!(io_rd || io_wr) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("cmd_rd", io_rd, !wr);
    check_eq("cmd_wr", io_wr, wr);
    check_eq("cmd_lba", io_lba, lba);
    io_ack = 1'b1;
    #1;
    check_eq("ack", req_ack, 2'b01 << own);
    @(posedge clk); #1;
    io_ack = 1'b0;
    if (!keep) begin
      req_rd[own] = 1'b0;
      req_wr[own] = 1'b0;
    end
    check_eq("cmd_drop", {io_rd, io_wr}, 0);
    for (int b = 0; b < BB; b++) begin
      if (b == abort_at) break;
      d = 8'(b) ^ lba[7:0];
      if (wr) begin
        req_dout[8*own +: 8]     = wpat(idx);
        req_dout[8*(1-own) +: 8] = 8'h55;
        io_dout_tvalid = 1'b1;
      end else begin
        io_din        = d;
        io_din_tvalid = 1'b1;
      end
      #1;
      if (wr) begin
        if (io_dout !== wpat(idx)) bad++;
        if (req_dout_taken[own]) idx++;
        if (req_dout_taken[1-own]) got_oth++;
      end else begin
        if (req_din_tvalid[own]) begin
          got_own++;
          if (req_din !== d) bad++;
        end
        if (req_din_tvalid[1-own]) got_oth++;
      end
      @(posedge clk); #1;
    end
    io_din_tvalid  = 1'b0;
    io_dout_tvalid = 1'b0;
    if (wr) got_own = idx;
    check_eq("bad_bytes", bad, 0);
    check_eq("stray_beats", got_oth, 0);
    if (abort_at < 0) begin
      check_eq("byte_count", got_own, BB);
      check_eq("done", req_done, 2'b01 << own);
      check_eq("err_idle", req_err, 0);
      @(posedge clk); #1;
      check_eq("done_pulse", req_done, 0);
    end else if (abort_rst) begin
      check_eq("byte_count_rst", got_own, abort_at);
      resetn = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_lba", io_lba, 0);
      check_eq("rst_cmd", {io_rd, io_wr}, 0);
      check_eq("rst_done_err", {req_done, req_err}, 0);
      resetn = 1'b1;
    end else begin
      check_eq("byte_count_abort", got_own, abort_at);
      disk_mounted = 1'b0;
      @(posedge clk); #1;
      check_eq("err", req_err, 2'b01 << own);
      check_eq("abort_done", req_done, 0);
      check_eq("abort_cmd", {io_rd, io_wr}, 0);
      @(posedge clk); #1;
      check_eq("err_pulse", req_err, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; disk_mounted = 1'b1;
    req_rd = '0; req_wr = '0; req_lba = '0; req_dout = '0;
    io_ack = 1'b0; io_din = '0; io_din_tvalid = 1'b0; io_dout_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_io", {io_rd, io_wr, io_lba}, 0);
    check_eq("rst_req", {req_ack, req_din_tvalid, req_dout_taken, req_done, req_err}, 0);
    check_eq("rst_stats", stat_blocks, 0);
    resetn = 1'b1;

    // T1: single read by requester 0
    req_lba[31:0] = 32'd5;
    req_rd[0] = 1'b1;
    xfer_block(0, 1'b0, 32'd5, -1, 1'b0, 1'b0);
    check_eq("stats_t1", stat_blocks, st(0, 1));

    // T2: write by requester 1
    req_lba[63:32] = 32'h0000_0A0B;
    req_wr[1] = 1'b1;
    xfer_block(1, 1'b1, 32'h0000_0A0B, -1, 1'b0, 1'b0);
    check_eq("stats_t2", stat_blocks, st(1, 1));

    // reset mid-transfer
    req_lba[31:0] = 32'hDEAD_BEEF;
    req_rd[0] = 1'b1;
    xfer_block(0, 1'b0, 32'hDEAD_BEEF, 50, 1'b1, 1'b0);
    check_eq("stats_rst", stat_blocks, 0);

    // T3: both requesters read three blocks each, alternating grants
    req_lba = {32'h0000_0200, 32'h0000_0100};
    req_rd  = 2'b11;
    for (int k = 0; k < 6; k++)
      xfer_block(k % 2, 1'b0, (k % 2 == 0) ? 32'h100 : 32'h200, -1, 1'b0, k < 4);
    check_eq("stats_t3", stat_blocks, st(3, 3));

    // T4: unmount after 100 bytes, no grant while unmounted
    req_lba[31:0] = 32'h44;
    req_rd[0] = 1'b1;
    xfer_block(0, 1'b0, 32'h44, 100, 1'b0, 1'b0);
    req_rd[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("unmounted_no_grant", {io_rd, io_wr}, 0);
    check_eq("stats_t4", stat_blocks, st(3, 3));
    disk_mounted = 1'b1;
    xfer_block(0, 1'b0, 32'h44, -1, 1'b0, 1'b0);

    // T5: rd and wr both set, read wins
    req_lba[31:0] = 32'h77;
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    xfer_block(0, 1'b0, 32'h77, -1, 1'b0, 1'b0);
    check_eq("stats_end", stat_blocks, st(3, 5));
    check_eq("idle_end", {io_rd, io_wr}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
